// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers in bursts of up to MAX_BURST beats.
// One IDLE cycle of arbitration before each grant. req_ready and fifo_wr_en fall combinationally with fifo_full.
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
    output logic                           grant_valid,
    output logic [ID_WIDTH-1:0]            grant_id
);

    localparam int CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [ID_WIDTH-1:0]    owner, owner_nxt;
    logic [ID_WIDTH-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;

    logic [DATA_WIDTH-1:0]  payload [NUM_REQ];
    logic                   sel_found;
    logic [ID_WIDTH-1:0]    sel_idx;
    logic [ID_WIDTH-1:0]    owner_inc;
    logic                   owner_vld;
    logic                   accept;
    logic                   last_beat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign payload[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the highest offset down so the last hit is the nearest to rr_ptr.
    always_comb begin
        int                  idx;
        logic [ID_WIDTH-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_WIDTH'(idx);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign owner_inc = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_vld = req_valid[owner];
    assign accept    = (state == BURST) && owner_vld && !fifo_full;
    assign last_beat = (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt    = BURST;
                    owner_nxt    = sel_idx;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                // A stalled owner keeps the grant only while its valid stays high.
                if (!owner_vld || (accept && last_beat)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_valid  = 1'b0;
        grant_id     = '0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state == BURST) begin
            grant_valid      = 1'b1;
            grant_id         = owner;
            req_ready[owner] = !fifo_full;
        end
        if (accept) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = {owner, payload[owner]};
        end
    end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NUM_REQ producers share one native-interface sync FIFO write port. Each producer has a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats. It drives the FIFO's wr_en/wr_data and observes its full flag. Each written word is tagged with the source ID so the consumer side can demultiplex.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
DATA_WIDTH, 8, payload width per requester.
MAX_BURST, 4, max accepted beats per grant; must be >= 1.
ID_WIDTH, $clog2(NUM_REQ), derived localparam; source tag width.

Ports:
clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester data valid.
req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  per-requester accept.
fifo_full  input  1  full flag from the shared FIFO.
fifo_wr_en  output  1  FIFO write enable.
fifo_wr_data  output  ID_WIDTH+DATA_WIDTH  {grant_id, payload}; FIFO DATA_WIDTH must equal this width.
grant_valid  output  1  a requester currently owns the port.
grant_id  output  ID_WIDTH  index of the owner; 0 when grant_valid=0.

Behaviour:
- State machine with two states: IDLE and BURST. Registers: state, owner (ID_WIDTH), rr_ptr (ID_WIDTH), beat_cnt (wide enough for MAX_BURST).
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, so grant_valid=0, grant_id=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- IDLE:
  - If any req_valid is high, select the first set index searching circularly from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - Next cycle: owner=that index, beat_cnt=0, state=BURST.
  - No data is accepted in IDLE, so there is 1 cycle of arbitration latency.
- BURST:
  - grant_valid=1 and grant_id=owner.
  - req_ready[owner] = !fifo_full, a combinational path from fifo_full. All other req_ready bits are 0.
  - A beat is accepted when req_valid[owner] && req_ready[owner]. In that cycle fifo_wr_en=1 and fifo_wr_data={owner, req_data[owner]}. fifo_wr_en is combinational, in the same cycle as the handshake.
  - When fifo_wr_en=0, fifo_wr_data=0.
  - Each accepted beat increments beat_cnt.
- Release from BURST to IDLE, with rr_ptr=(owner+1) mod NUM_REQ, happens when either:
  - a beat is accepted with beat_cnt==MAX_BURST-1, or
  - req_valid[owner]==0 in any BURST cycle (no beat is accepted in that cycle).
- After a release, IDLE arbitrates on the following cycle, giving 1 bubble cycle between grants. A requester that still has valid high after its burst is granted again only after all other valid requesters ahead of it in round-robin order.
- fifo_full during BURST: ready is low and no write happens. beat_cnt and the grant are held, so the owner keeps the grant while stalled as long as valid stays high. Dropping valid while stalled releases the grant.
- The arbiter never asserts fifo_wr_en while fifo_full=1. Payload and source ID are passed unmodified.
- Non-owner valid toggles have no effect during BURST.
- Requester index wrap: rr_ptr=NUM_REQ-1 searches NUM_REQ-1, 0, 1, ...; owner NUM_REQ-1 releases to rr_ptr=0.
- Reset mid-burst: all state returns to reset values immediately (async). The partial burst is abandoned; beats already written remain in the FIFO.
- Non-power-of-two NUM_REQ: rr_ptr and owner wrap at NUM_REQ, never at 2**ID_WIDTH.

Test Plan:
- Single requester: req_valid=4'b0010 for 6 beats with data 0x10..0x15, fifo_full=0. Response:
  - grant after 1 cycle, grant_id=1;
  - writes {2'd1,0x10}..{2'd1,0x13};
  - 1 IDLE bubble, then regrant to requester 1;
  - writes 0x14, 0x15.
- All four requesters valid continuously, MAX_BURST=4: grant order 0,1,2,3,0. Each grant delivers exactly 4 consecutive writes, with exactly 1 idle cycle between grants.
- fifo_full asserted for 3 cycles after the 2nd beat of requester 2's burst:
  - req_ready and fifo_wr_en are 0 for those 3 cycles;
  - grant_id stays 2;
  - beats 3 and 4 are written after full drops;
  - no write ever occurs while full=1.
- Requester 3 drops valid after 1 beat. The grant releases that cycle; next arbitration starts at rr_ptr=0 (wrap), and requester 0 is granted if valid.
- Async rst pulse mid-burst (owner=1, 2 beats done): immediately grant_valid=0, req_ready=0, fifo_wr_en=0. After release, arbitration restarts from rr_ptr=0.
- NUM_REQ=3 build, all valid: grant order 0,1,2,0. Index 3 is never granted.
